// File: rtl/accu_sequencer_pkg.sv
// Shared definitions for the accumulator sequencer: FSM state encoding,
// opcode values, ALU select codes and small decode helpers.
package accu_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_EXEC   = 3'd2,
    ST_ADDR   = 3'd3,
    ST_HALTED = 3'd4
  } state_t;

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_LIT   = 4'h1;
  localparam logic [3:0] OP_ADDI  = 4'h2;
  localparam logic [3:0] OP_CMPI  = 4'h3;
  localparam logic [3:0] OP_NANDI = 4'h4;
  localparam logic [3:0] OP_OUT   = 4'h5;
  localparam logic [3:0] OP_JMP   = 4'h6;
  localparam logic [3:0] OP_JC    = 4'h7;
  localparam logic [3:0] OP_JZ    = 4'h8;
  localparam logic [3:0] OP_JNC   = 4'h9;
  localparam logic [3:0] OP_JNZ   = 4'hA;
  localparam logic [3:0] OP_HALT  = 4'hF;

  localparam logic [2:0] ALU_PASS_A = 3'b000;
  localparam logic [2:0] ALU_CMP    = 3'b001;
  localparam logic [2:0] ALU_PASS_B = 3'b010;
  localparam logic [2:0] ALU_ADD    = 3'b011;
  localparam logic [2:0] ALU_NAND   = 3'b100;

  // Opcodes that carry an immediate operand and produce ALU flags.
  function automatic logic uses_imm(input logic [3:0] op);
    return (op == OP_LIT) || (op == OP_ADDI) || (op == OP_CMPI) || (op == OP_NANDI);
  endfunction

  // Branch condition evaluated against the flags held while in ADDR.
  function automatic logic jump_taken(input logic [3:0] op, input logic fc, input logic fz);
    logic t;
    case (op)
      OP_JMP:  t = 1'b1;
      OP_JC:   t = fc;
      OP_JZ:   t = fz;
      OP_JNC:  t = ~fc;
      OP_JNZ:  t = ~fz;
      default: t = 1'b0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/accu_decode.sv
// Combinational opcode-to-control decode for the accumulator sequencer.
// Ports:
//   opcode  in  4  IR[7:4]
//   exec    in  1  sequencer is in EXEC; all outputs are idle otherwise
//   s       out 3  ALU select
//   en_b1   out 1  operand-buffer enable
//   en_b2   out 1  output-buffer enable
//   en_accu out 1  accumulator write enable
//   is_jump out 1  opcode is one of JMP/JC/JZ/JNC/JNZ
//   is_halt out 1  opcode is HALT
module accu_decode
  import accu_sequencer_pkg::*;
(
  input  logic [3:0] opcode,
  input  logic       exec,
  output logic [2:0] s,
  output logic       en_b1,
  output logic       en_b2,
  output logic       en_accu,
  output logic       is_jump,
  output logic       is_halt
);

  always_comb begin
    s       = ALU_PASS_A;
    en_b1   = 1'b0;
    en_b2   = 1'b0;
    en_accu = 1'b0;
    is_jump = 1'b0;
    is_halt = 1'b0;
    if (exec) begin
      case (opcode)
        OP_LIT:   begin s = ALU_PASS_B; en_b1 = 1'b1; en_accu = 1'b1; end
        OP_ADDI:  begin s = ALU_ADD;    en_b1 = 1'b1; en_accu = 1'b1; end
        // Compare only updates flags; the accumulator keeps its value.
        OP_CMPI:  begin s = ALU_CMP;    en_b1 = 1'b1; end
        OP_NANDI: begin s = ALU_NAND;   en_b1 = 1'b1; en_accu = 1'b1; end
        OP_OUT:   begin s = ALU_PASS_A; en_b2 = 1'b1; end
        OP_JMP, OP_JC, OP_JZ, OP_JNC, OP_JNZ: is_jump = 1'b1;
        OP_HALT:  is_halt = 1'b1;
        default:  ; // NOP and unused opcodes 0xB-0xE
      endcase
    end
  end

endmodule

// File: rtl/accu_sequencer.sv
// Control sequencer for a 4-bit accumulator datapath. Fetches one byte per
// instruction from a combinational ROM, decodes it into ALU/buffer controls,
// latches ALU flags and handles conditional jumps with a one-byte target.
// Ports:
//   clk      in  1     clock, rising edge
//   reset    in  1     asynchronous active-high reset
//   run      in  1     start request, honoured only in IDLE
//   instr    in  8     ROM byte at address pc
//   carry    in  1     ALU carry/borrow
//   zero     in  1     ALU zero
//   pc       out PC_W  program address
//   oprnd    out 4     immediate to the B-side buffer
//   enB1     out 1     operand-buffer enable
//   enB2     out 1     output-buffer enable
//   en_accu  out 1     accumulator write enable
//   S        out 3     ALU select
//   flag_c   out 1     latched carry
//   flag_z   out 1     latched zero
//   halted   out 1     HALT executed; only reset leaves this state
module accu_sequencer
  import accu_sequencer_pkg::*;
#(
  parameter int PC_W = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            run,
  input  logic [7:0]      instr,
  input  logic            carry,
  input  logic            zero,
  output logic [PC_W-1:0] pc,
  output logic [3:0]      oprnd,
  output logic            enB1,
  output logic            enB2,
  output logic            en_accu,
  output logic [2:0]      S,
  output logic            flag_c,
  output logic            flag_z,
  output logic            halted
);

  state_t          state;
  logic [7:0]      ir;
  logic            in_exec;
  logic            is_jump;
  logic            is_halt;
  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] target;

  // Controls decode from registered state and IR only, so an asynchronous
  // reset (state -> IDLE) drops every enable without waiting for a clock.
  assign in_exec = (state == ST_EXEC);
  assign pc_inc  = pc + PC_W'(1);
  assign target  = PC_W'(instr);
  assign oprnd   = (in_exec && uses_imm(ir[7:4])) ? ir[3:0] : 4'h0;

  accu_decode u_decode (
    .opcode  (ir[7:4]),
    .exec    (in_exec),
    .s       (S),
    .en_b1   (enB1),
    .en_b2   (enB2),
    .en_accu (en_accu),
    .is_jump (is_jump),
    .is_halt (is_halt)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= ST_IDLE;
      pc     <= '0;
      ir     <= '0;
      flag_c <= 1'b0;
      flag_z <= 1'b0;
      halted <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (run) state <= ST_FETCH;
        end
        ST_FETCH: begin
          ir    <= instr;
          pc    <= pc_inc;
          state <= ST_EXEC;
        end
        ST_EXEC: begin
          if (uses_imm(ir[7:4])) begin
            flag_c <= carry;
            flag_z <= zero;
          end
          if (is_halt) begin
            state  <= ST_HALTED;
            halted <= 1'b1;
          end else if (is_jump) begin
            state <= ST_ADDR;
          end else begin
            state <= ST_FETCH;
          end
        end
        ST_ADDR: begin
          // pc points at the target byte; a skipped jump steps over it.
          pc    <= jump_taken(ir[7:4], flag_c, flag_z) ? target : pc_inc;
          state <= ST_FETCH;
        end
        ST_HALTED: state <= ST_HALTED;
        default:   state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_accu_sequencer.sv
module tb_accu_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       run;
  logic [7:0] instr;
  logic       carry;
  logic       zero;
  logic [7:0] pc;
  logic [3:0] oprnd;
  logic       enB1, enB2, en_accu;
  logic [2:0] S;
  logic       flag_c, flag_z, halted;

  logic [7:0] rom [256];
  int n_assert = 0;
  int n_fail   = 0;
  int exp_q[$];
  int cmpi_wr  = 0;

  // Datapath model: 4-bit accumulator, ALU, output buffer
  logic [3:0] acc = 4'h0;
  logic [3:0] out_buf = 4'h0;
  logic [3:0] b_val;
  logic [3:0] alu_r;
  logic       alu_c;

  always #5 clk = ~clk;

  assign instr = rom[pc];

  always_comb begin
    b_val = enB1 ? oprnd : 4'h0;
    alu_r = acc;
    alu_c = 1'b0;
    case (S)
      3'b010: alu_r = b_val;
      3'b011: {alu_c, alu_r} = {1'b0, acc} + {1'b0, b_val};
      3'b001: {alu_c, alu_r} = {1'b0, acc} - {1'b0, b_val};
      3'b100: alu_r = ~(acc & b_val);
      default: alu_r = acc;
    endcase
  end
  assign carry = alu_c;
  assign zero  = (alu_r == 4'h0);

  always @(posedge clk) begin
    if (en_accu) acc <= alu_r;
    if (enB2) out_buf <= alu_r;
  end

  accu_sequencer #(.PC_W(8)) dut (
    .clk     (clk),
    .reset   (reset),
    .run     (run),
    .instr   (instr),
    .carry   (carry),
    .zero    (zero),
    .pc      (pc),
    .oprnd   (oprnd),
    .enB1    (enB1),
    .enB2    (enB2),
    .en_accu (en_accu),
    .S       (S),
    .flag_c  (flag_c),
    .flag_z  (flag_z),
    .halted  (halted)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Scoreboard: each OUT pops the value it should present
  always @(negedge clk) begin
    if (!reset && enB2) begin
      if (exp_q.size() == 0) chk("out_unexpected", int'(alu_r), -1);
      else chk("out_value", int'(alu_r), exp_q.pop_front());
    end
    if (!reset && S == 3'b001 && en_accu) cmpi_wr++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    run   = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = 8'h00;
  endtask

  task automatic start();
    run = 1'b1;
    tick();
    run = 1'b0;
  endtask

  task automatic wait_halt(input int max_cycles);
    for (int k = 0; k < max_cycles && !halted; k++) tick();
    chk("halt_reached", int'(halted), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1, "timeout");
  end

  initial begin
    int cnt;
    int bad;
    int acc_snap;
    int cw;
    reset = 1'b1;
    run   = 1'b0;
    clear_rom();
    #1;
    // Reset state
    chk("rst_pc", int'(pc), 0);
    chk("rst_halted", int'(halted), 0);
    chk("rst_flags", int'({flag_c, flag_z}), 0);
    chk("rst_ctrl", int'({S, enB1, enB2, en_accu, oprnd}), 0);
    @(negedge clk);
    reset = 1'b0;
    tick(); tick();
    chk("idle_no_run_pc", int'(pc), 0);

    // LIT 5, ADDI 3, OUT, HALT
    do_reset(); clear_rom();
    rom[0] = 8'h15; rom[1] = 8'h23; rom[2] = 8'h50; rom[3] = 8'hF0;
    exp_q.push_back(8);
    start();
    tick();
    chk("lit_S", int'(S), 2);
    chk("lit_enB1", int'(enB1), 1);
    chk("lit_en_accu", int'(en_accu), 1);
    chk("lit_oprnd", int'(oprnd), 5);
    chk("lit_pc", int'(pc), 1);
    tick();
    chk("fetch_ctrl_idle", int'({S, enB1, enB2, en_accu, oprnd}), 0);
    tick(); tick(); tick();
    chk("out_enB2", int'(enB2), 1);
    chk("out_S", int'(S), 0);
    chk("out_oprnd", int'(oprnd), 0);
    wait_halt(10);
    chk("t1_outbuf", int'(out_buf), 8);
    chk("t1_pc", int'(pc), 4);

    // LIT F, ADDI 1, JC 0x20
    do_reset(); clear_rom();
    rom[0] = 8'h1F; rom[1] = 8'h21; rom[2] = 8'h70; rom[3] = 8'h20; rom[8'h20] = 8'hF0;
    start();
    tick(); tick(); tick(); tick();
    chk("addi_flag_c", int'(flag_c), 1);
    chk("addi_flag_z", int'(flag_z), 1);
    cnt = 0;
    while (pc != 8'h20 && cnt < 10) begin
      tick();
      cnt++;
    end
    chk("jc_cycles", cnt, 3);
    chk("jc_pc", int'(pc), 8'h20);
    wait_halt(10);
    chk("jc_halt_pc", int'(pc), 8'h21);

    // LIT 2, CMPI 3, JZ 0x40 (not taken)
    do_reset(); clear_rom();
    rom[0] = 8'h12; rom[1] = 8'h33; rom[2] = 8'h80; rom[3] = 8'h40; rom[4] = 8'hF0;
    cw = cmpi_wr;
    start();
    tick(); tick(); tick();
    chk("cmpi_S", int'(S), 1);
    chk("cmpi_enB1", int'(enB1), 1);
    chk("cmpi_en_accu", int'(en_accu), 0);
    chk("cmpi_oprnd", int'(oprnd), 3);
    tick();
    chk("cmpi_flag_z", int'(flag_z), 0);
    chk("cmpi_flag_c", int'(flag_c), 1);
    chk("cmpi_acc", int'(acc), 2);
    tick(); tick(); tick();
    chk("jz_skip_pc", int'(pc), 4);
    wait_halt(10);
    chk("cmpi_no_write", cmpi_wr - cw, 0);

    // JMP 0xFF, NOP at 0xFF -> pc wraps
    do_reset(); clear_rom();
    rom[0] = 8'h60; rom[1] = 8'hFF; rom[8'hFF] = 8'h00;
    start();
    tick(); tick(); tick();
    chk("jmp_pc", int'(pc), 8'hFF);
    tick();
    chk("wrap_pc", int'(pc), 0);

    // HALT, run ignored, reset recovers
    do_reset(); clear_rom();
    rom[0] = 8'hF0;
    start();
    tick();
    chk("halt_exec_halted", int'(halted), 0);
    tick();
    chk("halt_next_cycle", int'(halted), 1);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      run = i[0];
      tick();
      if (pc != 8'h01 || !halted || enB1 || enB2 || en_accu) bad++;
    end
    run = 1'b0;
    chk("halt_frozen", bad, 0);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("halt_rst_pc", int'(pc), 0);
    chk("halt_rst_halted", int'(halted), 0);
    @(negedge clk);
    reset = 1'b0;
    tick(); tick();
    chk("post_rst_idle_pc", int'(pc), 0);
    start();
    tick();
    chk("post_rst_run_pc", int'(pc), 1);
    wait_halt(5);

    // Async reset mid-EXEC of ADDI
    do_reset(); clear_rom();
    rom[0] = 8'h1F; rom[1] = 8'h21; rom[2] = 8'h22; rom[3] = 8'hF0;
    start();
    tick(); tick(); tick(); tick();
    chk("pre_rst_flags", int'({flag_c, flag_z}), 3);
    tick();
    chk("pre_rst_en_accu", int'(en_accu), 1);
    acc_snap = int'(acc);
    #2 reset = 1'b1;
    #1;
    chk("async_en_accu", int'(en_accu), 0);
    chk("async_ctrl", int'({S, enB1, enB2, oprnd}), 0);
    chk("async_pc", int'(pc), 0);
    chk("async_flags", int'({flag_c, flag_z, halted}), 0);
    tick();
    chk("async_no_acc_write", int'(acc), acc_snap);
    @(negedge clk);
    reset = 1'b0;

    // LIT C, NOP-class 0xB5, NANDI A, OUT, JNC 0x08, OUT at 0x08
    do_reset(); clear_rom();
    rom[0] = 8'h1C; rom[1] = 8'hB5; rom[2] = 8'h4A; rom[3] = 8'h50;
    rom[4] = 8'h90; rom[5] = 8'h08; rom[6] = 8'h50; rom[8] = 8'h50; rom[9] = 8'hF0;
    exp_q.push_back(7);
    exp_q.push_back(7);
    start();
    tick(); tick(); tick();
    chk("nop_b_ctrl", int'({S, enB1, enB2, en_accu, oprnd}), 0);
    wait_halt(40);
    chk("jnc_end_pc", int'(pc), 10);
    chk("sb_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
